// File: rtl/game_ctrl_pkg.sv
// Shared game constants: FSM state codes, playfield geometry and score helpers.
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int unsigned PF_VBUF_W   = 320;
  localparam int unsigned PF_VBUF_H   = 240;
  localparam int unsigned PF_GROUND_Y = 220;
  localparam int unsigned PF_NET_POS  = 160;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned SCORE_W = 4;

  // Score increment that sticks at the top of the counter range.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/game_ctrl_btn_edge.sv
// Start-button synchronizer with registered rising-edge pulse.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync0;
  logic sync1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      pulse <= sync0 & ~sync1;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Match controller: serve/rally/point sequencing, landing detection and scoring.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned VBUF_W      = PF_VBUF_W,
  parameter int unsigned VBUF_H      = PF_VBUF_H,
  parameter int unsigned GROUND_Y    = PF_GROUND_Y,
  parameter int unsigned NET_POS     = PF_NET_POS,
  parameter int unsigned BALL_SIZE   = 32,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned RST_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic [COORD_W-1:0] ball_pos_x,
  input  logic [COORD_W-1:0] ball_pos_y,
  output logic               round_rst_n,
  output logic               freeze,
  output logic               serve_side,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic [2:0]         state
);

  localparam int unsigned CNT_MAX = (HOLD_FRAMES > RST_CYCLES) ? HOLD_FRAMES : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SUM_W   = COORD_W + 1;

  if (GROUND_Y > VBUF_H || NET_POS > VBUF_W || BALL_SIZE > GROUND_Y) begin : g_bad_cfg
    $error("game_ctrl: inconsistent playfield parameters");
  end

  logic start_pulse;

  btn_edge u_btn_edge (
    .clk   (clk),
    .rst_n (reset_n),
    .btn   (start_btn),
    .pulse (start_pulse)
  );

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               fresh_q;
  logic [SCORE_W-1:0] score_l_nxt, score_r_nxt;
  logic               serve_nxt, freeze_nxt, round_rst_n_nxt, game_over_nxt;
  logic [SUM_W-1:0]   ball_bottom_c, ball_cx_c;
  logic               landing_c, right_scores_c, win_c;

  // fresh_q marks the first cycle spent in a state; ticks there are not acted on.
  assign ball_bottom_c  = SUM_W'(ball_pos_y) + SUM_W'(BALL_SIZE);
  assign ball_cx_c      = SUM_W'(ball_pos_x) + SUM_W'(BALL_SIZE / 2);
  assign landing_c      = frame_tick && !fresh_q && (ball_bottom_c >= SUM_W'(GROUND_Y));
  assign right_scores_c = ball_cx_c < SUM_W'(NET_POS);
  assign win_c          = (score_l >= SCORE_W'(WIN_SCORE)) || (score_r >= SCORE_W'(WIN_SCORE));

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    score_l_nxt = score_l;
    score_r_nxt = score_r;
    serve_nxt   = serve_side;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_pulse) begin
          score_l_nxt = '0;
          score_r_nxt = '0;
          serve_nxt   = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_PLAY;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ST_PLAY: begin
        if (landing_c) begin
          if (right_scores_c) begin
            score_r_nxt = sat_inc(score_r);
            serve_nxt   = 1'b1;
          end else begin
            score_l_nxt = sat_inc(score_l);
            serve_nxt   = 1'b0;
          end
          cnt_nxt   = '0;
          state_nxt = ST_POINT;
        end
      end
      ST_POINT: begin
        if (frame_tick && !fresh_q) begin
          if (cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
            cnt_nxt   = '0;
            state_nxt = win_c ? ST_OVER : ST_SERVE;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase

    // Mover controls follow the state being entered so they register alongside it.
    freeze_nxt      = (state_nxt == ST_IDLE) || (state_nxt == ST_POINT) || (state_nxt == ST_OVER);
    round_rst_n_nxt = !((state_nxt == ST_IDLE) || (state_nxt == ST_SERVE));
    game_over_nxt   = (state_nxt == ST_OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fresh_q     <= 1'b0;
      score_l     <= '0;
      score_r     <= '0;
      serve_side  <= 1'b0;
      freeze      <= 1'b1;
      round_rst_n <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      fresh_q     <= (state_nxt != state_q);
      score_l     <= score_l_nxt;
      score_r     <= score_r_nxt;
      serve_side  <= serve_nxt;
      freeze      <= freeze_nxt;
      round_rst_n <= round_rst_n_nxt;
      game_over   <= game_over_nxt;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed match flow plus randomized rallies
// scored by a rally-level reference model.
module tb_game_ctrl;

  localparam int GROUND   = 220;
  localparam int NET      = 160;
  localparam int BALL     = 32;
  localparam int WIN      = 7;
  localparam int HOLD     = 60;
  localparam int RSTC     = 4;
  localparam int S_IDLE   = 0;
  localparam int S_SERVE  = 1;
  localparam int S_PLAY   = 2;
  localparam int S_POINT  = 3;
  localparam int S_OVER   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic        start_btn;
  logic [11:0] ball_pos_x;
  logic [11:0] ball_pos_y;
  logic        round_rst_n;
  logic        freeze;
  logic        serve_side;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        game_over;
  logic [2:0]  state;

  int checks = 0;
  int passes = 0;

  // Reference model of the match: scores and serving side.
  int m_l = 0;
  int m_r = 0;
  int m_serve = 0;

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .ball_pos_x  (ball_pos_x),
    .ball_pos_y  (ball_pos_y),
    .round_rst_n (round_rst_n),
    .freeze      (freeze),
    .serve_side  (serve_side),
    .score_l     (score_l),
    .score_r     (score_r),
    .game_over   (game_over),
    .state       (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_scores(input string tag);
    chk({tag, "_score_l"}, 32'(score_l), 32'(m_l));
    chk({tag, "_score_r"}, 32'(score_r), 32'(m_r));
    chk({tag, "_serve"}, 32'(serve_side), 32'(m_serve));
  endtask

  // Counts SERVE cycles starting at the first sampled SERVE cycle.
  task automatic run_serve();
    int n;
    n = 0;
    chk("serve_freeze", 32'(freeze), 0);
    while (state == 3'(S_SERVE) && round_rst_n == 1'b0 && n < 20) begin
      n++;
      step();
    end
    chk("serve_len", 32'(n), 32'(RSTC));
    chk("serve_to_play", 32'(state), S_PLAY);
    chk("play_rrst", 32'(round_rst_n), 1);
  endtask

  task automatic press_start();
    int n;
    n = 0;
    start_btn = 1'b1;
    while (state != 3'(S_SERVE) && n < 8) begin
      step();
      n++;
    end
    start_btn = 1'b0;
    chk("start_latency_ok", 32'(n >= 2 && n <= 3), 1);
    m_l = 0;
    m_r = 0;
    m_serve = 0;
    chk_scores("start");
  endtask

  // One rally in PLAY past the entry cycle: a single frame tick with the ball at (x,y).
  task automatic rally(input int x, input int y);
    bit land;
    ball_pos_x = 12'(x);
    ball_pos_y = 12'(y);
    frame_tick = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    land = (y + BALL >= GROUND);
    if (land) begin
      if (x + BALL / 2 < NET) begin
        m_r = (m_r < 15) ? m_r + 1 : 15;
        m_serve = 1;
      end else begin
        m_l = (m_l < 15) ? m_l + 1 : 15;
        m_serve = 0;
      end
    end
    chk("rally_state", 32'(state), land ? S_POINT : S_PLAY);
    chk_scores("rally");
  endtask

  // POINT hold entered on the current cycle; optionally reset after tick abort_at.
  task automatic hold(input int abort_at, output int next_state);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("hold_freeze", 32'(freeze), 1);
    for (int i = 1; i <= HOLD; i++) begin
      step();
      if (i == HOLD) chk("hold_last_pre", 32'(state), S_POINT);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (i == abort_at) begin
        #1 reset_n = 1'b0;
        #1;
        m_l = 0;
        m_r = 0;
        m_serve = 0;
        chk("abort_state", 32'(state), S_IDLE);
        chk_scores("abort");
        chk("abort_freeze", 32'(freeze), 1);
        chk("abort_rrst", 32'(round_rst_n), 0);
        next_state = S_IDLE;
        return;
      end
    end
    next_state = (m_l >= WIN || m_r >= WIN) ? S_OVER : S_SERVE;
    chk("hold_exit", 32'(state), 32'(next_state));
  endtask

  initial begin
    int ns;
    int guard;
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    ball_pos_x = '0;
    ball_pos_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), S_IDLE);
    chk_scores("rst");
    chk("rst_freeze", 32'(freeze), 1);
    chk("rst_rrst", 32'(round_rst_n), 0);
    chk("rst_over", 32'(game_over), 0);
    reset_n = 1'b1;
    repeat (4) step();
    chk("idle_hold", 32'(state), S_IDLE);

    press_start();
    run_serve();

    // A tick on the PLAY entry cycle with a landed ball must be ignored.
    ball_pos_x = 12'd100;
    ball_pos_y = 12'd190;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("entry_tick_state", 32'(state), S_PLAY);
    chk_scores("entry_tick");

    // Landed ball without ticks, plus a start press, must not change anything.
    start_btn = 1'b1;
    repeat (3) step();
    start_btn = 1'b0;
    repeat (6) step();
    chk("no_tick_state", 32'(state), S_PLAY);
    chk_scores("no_tick");

    rally(100, 190);
    hold(-1, ns);
    run_serve();

    rally(144, 187);
    rally(144, 188);
    hold(-1, ns);
    run_serve();

    // Random rallies, then left-side landings until the match ends.
    for (int k = 0; k < 4; k++) begin
      rally(int'($urandom_range(0, 300)), int'($urandom_range(150, 215)));
      if (state == 3'(S_POINT)) begin
        hold(-1, ns);
        run_serve();
      end
    end
    ns = S_SERVE;
    guard = 0;
    while (ns != S_OVER && guard < 12) begin
      guard++;
      rally(int'($urandom_range(144, 300)), int'($urandom_range(188, 220)));
      hold(-1, ns);
      if (ns == S_SERVE) run_serve();
    end
    chk("over_reached", 32'(ns), S_OVER);
    chk("over_state", 32'(state), S_OVER);
    chk("over_flag", 32'(game_over), 1);
    chk("over_freeze", 32'(freeze), 1);
    chk("over_left_won", 32'(m_l >= WIN), 1);

    press_start();
    chk("over_restart_flag", 32'(game_over), 0);
    run_serve();

    rally(50, 200);
    hold(30, ns);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      frame_tick = k[0];
      step();
    end
    frame_tick = 1'b0;
    chk("post_abort_idle", 32'(state), S_IDLE);
    chk_scores("post_abort");

    press_start();
    chk("final_serve", 32'(state), S_SERVE);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
